// File: rtl/prescaled_updown_counter.sv
// rtl/prescaled_updown_counter.sv - prescaled up/down counter with load, enable, tick and terminal-count pulses
// Optional macro COUNTER_SAT_EN selects saturating bounds instead of modulo wrap.
module prescaled_updown_counter #(
    parameter int WIDTH = 3,
    parameter int DIV   = 8000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [PW-1:0]    presc;
    logic             presc_last;
    logic [WIDTH-1:0] step_val;
    logic             step_tc;

    assign presc_last = (presc == PRESC_LAST);

    // Next count and terminal flag for a tick; only used when a tick fires.
    always_comb begin
        step_val = count;
        step_tc  = 1'b0;
`ifdef COUNTER_SAT_EN
        if (!dir) begin
            if (count == CNT_MAX) begin
                step_tc = 1'b1;
            end else begin
                step_val = count + CNT_ONE;
            end
        end else begin
            if (count == '0) begin
                step_tc = 1'b1;
            end else begin
                step_val = count - CNT_ONE;
            end
        end
`else
        if (!dir) begin
            step_val = count + CNT_ONE;
            step_tc  = (count == CNT_MAX);
        end else begin
            step_val = count - CNT_ONE;
            step_tc  = (count == '0);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            count <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (load) begin
            presc <= '0;
            count <= load_val;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (en && presc_last) begin
            presc <= '0;
            count <= step_val;
            tick  <= 1'b1;
            tc    <= step_tc;
        end else begin
            if (en) begin
                presc <= presc + PRESC_ONE;
            end
            tick <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb/tb_prescaled_updown_counter.sv - directed self-checking bench for prescaled_updown_counter
module tb_prescaled_updown_counter;

`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] count;
    logic       tick;
    logic       tc;
    logic [2:0] count1;
    logic       tick1;
    logic       tc1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prescaled_updown_counter #(.WIDTH(3), .DIV(4)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .count(count), .tick(tick), .tc(tc)
    );

    prescaled_updown_counter #(.WIDTH(3), .DIV(1)) dut_div1 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .count(count1), .tick(tick1), .tc(tc1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 3'd0;
        #1;
        step();
        step();
        tests++;
        if ({count, tick, tc} !== 5'b0) begin
            fails++;
            $display("FAIL reset_state: count=%0d tick=%0b tc=%0b, expected 0 0 0", count, tick, tc);
        end
        reset = 1'b1;
        step();
        do_load(3'd5);
        en = 1'b1;
        step();
        step();
        tests++;
        if (count !== 3'd5) begin
            fails++;
            $display("FAIL pre_reset_count: count=%0d, expected 5", count);
        end
        #3;
        reset = 1'b0;
        #1;
        tests++;
        if ({count, tick, tc} !== 5'b0) begin
            fails++;
            $display("FAIL async_reset: count=%0d tick=%0b tc=%0b, expected 0 0 0", count, tick, tc);
        end
        step();
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if ({count, tick, tc} !== {(i == 4) ? 3'd1 : 3'd0, i == 4, 1'b0}) begin
                fails++;
                $display("FAIL first_tick cyc%0d: count=%0d tick=%0b tc=%0b, expected %0d %0b 0",
                         i, count, tick, tc, (i == 4) ? 1 : 0, i == 4);
            end
        end
    endtask

    task automatic test_count_up();
        logic [2:0] ec;
        logic       et;
        logic       etc;
        do_load(3'd0);
        en = 1'b1; dir = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            step();
            et  = (c % 4 == 0);
            etc = (c == 32);
            ec  = (c == 32) ? (SAT ? 3'd7 : 3'd0) : 3'(c / 4);
            tests++;
            if ({count, tick, tc} !== {ec, et, etc}) begin
                fails++;
                $display("FAIL count_up cyc%0d: count=%0d tick=%0b tc=%0b, expected %0d %0b %0b",
                         c, count, tick, tc, ec, et, etc);
            end
        end
    endtask

    task automatic test_count_down();
        do_load(3'd0);
        en = 1'b1; dir = 1'b1;
        repeat (4) step();
        tests++;
        if ({count, tick, tc} !== {SAT ? 3'd0 : 3'd7, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL down_bound: count=%0d tick=%0b tc=%0b, expected %0d 1 1",
                     count, tick, tc, SAT ? 0 : 7);
        end
        step();
        tests++;
        if ({tick, tc} !== 2'b00) begin
            fails++;
            $display("FAIL down_pulse_width: tick=%0b tc=%0b, expected 0 0", tick, tc);
        end
        repeat (3) step();
        tests++;
        if ({count, tick, tc} !== {SAT ? 3'd0 : 3'd6, 1'b1, SAT}) begin
            fails++;
            $display("FAIL down_second: count=%0d tick=%0b tc=%0b, expected %0d 1 %0b",
                     count, tick, tc, SAT ? 0 : 6, SAT);
        end
    endtask

    task automatic test_load_on_tick();
        do_load(3'd0);
        en = 1'b1; dir = 1'b0;
        repeat (3) step();
        load = 1'b1; load_val = 3'd5;
        step();
        load = 1'b0;
        tests++;
        if ({count, tick, tc} !== {3'd5, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL load_over_tick: count=%0d tick=%0b tc=%0b, expected 5 0 0", count, tick, tc);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if ({count, tick} !== {(i == 4) ? 3'd6 : 3'd5, i == 4}) begin
                fails++;
                $display("FAIL after_load cyc%0d: count=%0d tick=%0b, expected %0d %0b",
                         i, count, tick, (i == 4) ? 6 : 5, i == 4);
            end
        end
    endtask

    task automatic test_en_freeze();
        do_load(3'd0);
        en = 1'b1; dir = 1'b0;
        step();
        step();
        en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            tests++;
            if ({count, tick, tc} !== 5'b0) begin
                fails++;
                $display("FAIL frozen cyc%0d: count=%0d tick=%0b tc=%0b, expected 0 0 0",
                         i, count, tick, tc);
            end
        end
        en = 1'b1;
        step();
        tests++;
        if (tick !== 1'b0) begin
            fails++;
            $display("FAIL resume_early: tick=%0b, expected 0", tick);
        end
        step();
        tests++;
        if ({count, tick} !== {3'd1, 1'b1}) begin
            fails++;
            $display("FAIL resume_tick: count=%0d tick=%0b, expected 1 1", count, tick);
        end
        en = 1'b0;
        step();
        tests++;
        if ({count, tick, tc} !== {3'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL en_drop: count=%0d tick=%0b tc=%0b, expected 1 0 0", count, tick, tc);
        end
    endtask

    task automatic test_div1();
        logic [2:0] ec;
        logic       etc;
        do_load(3'd0);
        en = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (SAT) begin
                ec  = (i > 7) ? 3'd7 : 3'(i);
                etc = (i >= 8);
            end else begin
                ec  = 3'(i % 8);
                etc = (i == 8);
            end
            tests++;
            if ({count1, tick1, tc1} !== {ec, 1'b1, etc}) begin
                fails++;
                $display("FAIL div1 cyc%0d: count=%0d tick=%0b tc=%0b, expected %0d 1 %0b",
                         i, count1, tick1, tc1, ec, etc);
            end
        end
        en = 1'b0;
        step();
        tests++;
        if ({count1, tick1} !== {SAT ? 3'd7 : 3'd1, 1'b0}) begin
            fails++;
            $display("FAIL div1_en_off: count=%0d tick=%0b, expected %0d 0", count1, tick1, SAT ? 7 : 1);
        end
    endtask

    task automatic test_bound();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd7;
        exp_seq[1] = SAT ? 3'd7 : 3'd0;
        exp_seq[2] = SAT ? 3'd7 : 3'd1;
        exp_seq[3] = SAT ? 3'd7 : 3'd2;
        do_load(3'd6);
        en = 1'b1; dir = 1'b0;
        for (int t = 0; t < 4; t++) begin
            repeat (4) step();
            tests++;
            if ({count, tick, tc} !== {exp_seq[t], 1'b1, (t == 1) || (SAT && t > 0)}) begin
                fails++;
                $display("FAIL bound tick%0d: count=%0d tick=%0b tc=%0b, expected %0d 1 %0b",
                         t, count, tick, tc, exp_seq[t], (t == 1) || (SAT && t > 0));
            end
        end
        dir = 1'b1;
        repeat (4) step();
        tests++;
        if ({count, tick, tc} !== {SAT ? 3'd6 : 3'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL bound_reverse: count=%0d tick=%0b tc=%0b, expected %0d 1 0",
                     count, tick, tc, SAT ? 6 : 1);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_on_tick();
        test_en_freeze();
        test_div1();
        test_bound();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
